// File: rtl/program_loader.sv
// Packs decoded instruction fields into 16-bit words and writes them to consecutive program-memory addresses.
// Latency: 1 cycle from handshake to mem_we. Throughput: 1 word per 2 cycles. in_ready is low except in ACCEPT.
module program_loader #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [1:0]    cond,
    input  logic [3:0]    op,
    input  logic [2:0]    destreg_sel,
    input  logic [2:0]    srcreg1_sel,
    input  logic [2:0]    srcreg2_sel,
    input  logic [3:0]    shift,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          load_done,
    output logic [AW:0]   word_count,
    output logic          enc_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          last_q, last_d;
    logic [15:0]   word_q, word_d;

    logic          shift_form;
    logic [3:0]    operand;
    logic [15:0]   enc_word;
    logic          hs;

    assign shift_form = (op[3:2] == 2'b11);
    assign operand    = shift_form ? shift : {1'b0, srcreg2_sel};
    assign enc_word   = {cond, op, destreg_sel, srcreg1_sel, operand};

    // Gating with rst keeps a write from landing on the same edge that resets the FSM.
    assign in_ready   = (state_q == S_ACCEPT) && rst;
    assign mem_we     = (state_q == S_WRITE) && rst;
    assign hs         = in_valid && in_ready;

    assign mem_addr   = ptr_q;
    assign mem_wdata  = word_q;
    assign load_done  = (state_q == S_DONE);
    assign word_count = cnt_q;
    assign enc_err    = err_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        last_d  = last_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    state_d = S_ACCEPT;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (hs) begin
                    word_d  = enc_word;
                    last_d  = in_last || (ptr_q == PTR_MAX);
                    state_d = S_WRITE;
                    if (!shift_form && (shift != 4'd0)) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + 1'b1;
                // Pointer saturates at the top address instead of wrapping.
                if (ptr_q != PTR_MAX) begin
                    ptr_d = ptr_q + 1'b1;
                end
                state_d = last_q ? S_DONE : S_ACCEPT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            last_q  <= last_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: hand-computed instruction words checked at each write.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [1:0]  cond;
    logic [3:0]  op;
    logic [2:0]  destreg_sel;
    logic [2:0]  srcreg1_sel;
    logic [2:0]  srcreg2_sel;
    logic [3:0]  shift;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        load_done;
    logic [3:0]  word_count;
    logic        enc_err;

    int vectors = 0;
    int miscompares = 0;
    int n_wr = 0;
    logic [2:0]  wr_addr[$];
    logic [15:0] wr_data[$];

    program_loader #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .cond(cond), .op(op), .destreg_sel(destreg_sel),
        .srcreg1_sel(srcreg1_sel), .srcreg2_sel(srcreg2_sel), .shift(shift),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .load_done(load_done), .word_count(word_count), .enc_err(enc_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            n_wr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic set_fields(input logic [1:0] c, input logic [3:0] o, input logic [2:0] d,
                              input logic [2:0] s1, input logic [2:0] s2, input logic [3:0] sh,
                              input logic lst);
        cond = c; op = o; destreg_sel = d; srcreg1_sel = s1; srcreg2_sel = s2;
        shift = sh; in_last = lst; in_valid = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        vectors++;
        assert (waited < 20) else begin
            miscompares++;
            $error("FAIL %s_timeout: in_ready observed %b after %0d cycles, expected 1", tag, in_ready, waited);
        end
    endtask

    task automatic send(input string tag, input logic [1:0] c, input logic [3:0] o,
                        input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [3:0] sh, input logic lst,
                        input logic [2:0] exp_addr, input logic [15:0] exp_word);
        set_fields(c, o, d, s1, s2, sh, lst);
        wait_ready(tag);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_we"},    mem_we,    1);
        chk({tag, "_addr"},  mem_addr,  exp_addr);
        chk({tag, "_wdata"}, mem_wdata, exp_word);
        tick();
        chk({tag, "_we_pulse"}, mem_we, 0);
    endtask

    initial begin
        int n_before;
        rst = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        cond = '0; op = '0; destreg_sel = '0; srcreg1_sel = '0; srcreg2_sel = '0; shift = '0;
        repeat (3) tick();

        chk("rst_in_ready",   in_ready,   0);
        chk("rst_mem_we",     mem_we,     0);
        chk("rst_mem_addr",   mem_addr,   0);
        chk("rst_mem_wdata",  mem_wdata,  0);
        chk("rst_load_done",  load_done,  0);
        chk("rst_word_count", word_count, 0);
        chk("rst_enc_err",    enc_err,    0);
        rst = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 0);

        // Three-instruction program
        pulse_start();
        chk("t1_ready", in_ready, 1);
        send("t1_i0", 2'd0, 4'h0, 3'd1, 3'd2, 3'd3, 4'd0, 1'b0, 3'd0, 16'h00A3);
        send("t1_i1", 2'd3, 4'h5, 3'd7, 3'd0, 3'd1, 4'd0, 1'b0, 3'd1, 16'hD781);
        send("t1_i2", 2'd1, 4'h2, 3'd3, 3'd4, 3'd5, 4'd0, 1'b1, 3'd2, 16'h49C5);
        chk("t1_nwr",       n_wr,       3);
        chk("t1_addr0",     wr_addr[0], 0);
        chk("t1_addr2",     wr_addr[2], 2);
        chk("t1_data2",     wr_data[2], 16'h49C5);
        chk("t1_done",      load_done,  1);
        chk("t1_count",     word_count, 3);
        chk("t1_err",       enc_err,    0);
        tick();
        chk("t1_done_hold", load_done,  1);

        // Shift-form op ignores srcreg2_sel
        pulse_start();
        chk("t2_done_drop", load_done, 0);
        send("t2_i0", 2'd2, 4'hC, 3'd1, 3'd6, 3'd5, 4'h7, 1'b1, 3'd0, 16'hB0E7);
        chk("t2_err",   enc_err,    0);
        chk("t2_count", word_count, 1);

        // Register-form op with nonzero shift flags a sticky error
        pulse_start();
        send("t3_i0", 2'd0, 4'h1, 3'd2, 3'd3, 3'd5, 4'h2, 1'b0, 3'd0, 16'h0535);
        chk("t3_err_set", enc_err, 1);
        send("t3_i1", 2'd1, 4'h3, 3'd0, 3'd1, 3'd2, 4'h0, 1'b1, 3'd1, 16'h4C12);
        chk("t3_err_sticky", enc_err,   1);
        chk("t3_done",       load_done, 1);
        pulse_start();
        chk("t3_err_clr", enc_err, 0);

        // Eight words with in_last low: capacity forces DONE
        for (int i = 0; i < 8; i++) begin
            send("t4", 2'd3, 4'h4, 3'(i), 3'(7 - i), 3'(i), 4'h0, 1'b0, 3'(i),
                 {2'b11, 4'h4, 3'(i), 3'(7 - i), 1'b0, 3'(i)});
        end
        chk("t4_done",  load_done,  1);
        chk("t4_count", word_count, 8);
        chk("t4_err",   enc_err,    0);
        n_before = n_wr;
        set_fields(2'd0, 4'h0, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_no_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        chk("t4_no_write", n_wr, n_before);

        // Reset during the second write
        pulse_start();
        send("t5_i0", 2'd0, 4'h6, 3'd5, 3'd5, 3'd5, 4'h0, 1'b0, 3'd0, 16'h1AD5);
        set_fields(2'd1, 4'h1, 3'd1, 3'd1, 3'd1, 4'h0, 1'b0);
        wait_ready("t5_i1");
        tick();
        in_valid = 1'b0;
        chk("t5_we_before_rst", mem_we, 1);
        rst = 1'b0;
        #1;
        chk("t5_we_gated", mem_we, 0);
        n_before = n_wr;
        tick();
        rst = 1'b1;
        chk("t5_no_write", n_wr,       n_before);
        chk("t5_count",    word_count, 0);
        chk("t5_ready",    in_ready,   0);
        chk("t5_done",     load_done,  0);
        chk("t5_wdata",    mem_wdata,  0);
        pulse_start();
        send("t5_restart", 2'd2, 4'h8, 3'd2, 3'd1, 3'd7, 4'h0, 1'b1, 3'd0, 16'hA117);

        // in_valid held high: one write every two cycles, load_start ignored
        pulse_start();
        n_before = n_wr;
        set_fields(2'd0, 4'hF, 3'd0, 3'd0, 3'd0, 4'h3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            load_start = (i == 2 || i == 3);
            chk("t6_ready", in_ready, (i % 2 == 0));
            chk("t6_we",    mem_we,   (i % 2 == 1));
            tick();
        end
        load_start = 1'b0;
        in_valid   = 1'b0;
        chk("t6_nwr",   n_wr - n_before,      3);
        chk("t6_addr2", wr_addr[n_before + 2], 2);
        chk("t6_data",  wr_data[n_before + 1], 16'h3C03);
        chk("t6_count", word_count,           3);
        chk("t6_ptr",   mem_addr,             3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
